cash_data_bank: RTL and testbench
=================================

CASH_DATA_BANK -- requirements
Module: cash_data_bank

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of one stored data word.
REQ-002 SHALL have parameter DEPTH, default 16, number of entries; legal range DEPTH >= 2, not necessarily a power of two.
REQ-003 SHALL have derived parameter ADDR_WIDTH = $clog2(DEPTH), entry index width.
REQ-004 SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-006 SHALL have port req_valid, input, 1, request present.
REQ-007 SHALL have port req_ready, output, 1, bank can accept a request.
REQ-008 SHALL have port req_op, input, 2, operation: 00 read, 01 write, 10 delete, 11 clear-all.
REQ-009 SHALL have port req_addr, input, ADDR_WIDTH, entry index; ignored for clear-all.
REQ-010 SHALL have port req_data, input, DATA_WIDTH, write data; ignored for other ops.
REQ-011 SHALL have port rsp_valid, output, 1, one-cycle response strobe.
REQ-012 SHALL have port rsp_data, output, DATA_WIDTH, entry contents before the operation.
REQ-013 SHALL have port rsp_hit, output, 1, entry was valid before the operation.
REQ-014 SHALL have port count, output, ADDR_WIDTH+1, number of valid entries.
REQ-015 SHALL have port busy, output, 1, clear-all sweep in progress.

Function
REQ-016 SHALL hold per entry a DATA_WIDTH data register and a valid bit.
REQ-017 SHALL implement FSM states IDLE and CLEAR; req_ready = (state == IDLE) and not reset; busy = (state == CLEAR).
REQ-018 SHALL accept a request only in a cycle where req_valid and req_ready are both 1; req_valid while req_ready is 0 has no effect.
REQ-019 SHALL, for every accepted read/write/delete, pulse rsp_valid for exactly one cycle, the cycle after acceptance (latency 1), with rsp_data = prior entry data (0 if invalid) and rsp_hit = prior valid bit.
REQ-020 Read SHALL leave entry and count unchanged.
REQ-021 Write SHALL store req_data, set valid; count +1 only if entry was invalid, unchanged on overwrite.
REQ-022 Delete SHALL zero the data, clear valid; count -1 only if entry was valid; delete of an invalid entry changes nothing.
REQ-023 Request with req_addr >= DEPTH SHALL modify nothing and respond rsp_hit = 0, rsp_data = 0.
REQ-024 Back-to-back accepted requests SHALL be supported every cycle; a request to the entry written in the previous cycle SHALL see the new contents.
REQ-025 Accepted clear-all SHALL enter CLEAR; index sweeps 0..DEPTH-1, one entry per cycle, zeroing data and valid, count -1 per valid entry cleared.
REQ-026 After clearing entry DEPTH-1 the FSM SHALL return to IDLE; rsp_valid SHALL pulse in that same cycle (rsp_hit = 0, rsp_data = 0); clear-all latency is DEPTH cycles from acceptance to response, count = 0 at response.
REQ-027 rsp_data and rsp_hit SHALL be 0 whenever rsp_valid is 0.
REQ-028 count SHALL never exceed DEPTH nor wrap below 0.

Reset
REQ-029 When reset is 1 at a clock edge: all entry data 0, all valid 0, count 0, rsp_valid 0, rsp_data 0, rsp_hit 0, state IDLE, sweep index 0.
REQ-030 Reset SHALL take priority over any request and SHALL abort a clear-all sweep in progress without a response pulse.
REQ-031 Power-up initial values SHALL equal reset values.

Verification (DATA_WIDTH=32, DEPTH=16)
REQ-032 Write addr 3 = 0xDEADBEEF, then read addr 3 -> write rsp hit=0 data=0, count=1; read rsp hit=1 data=0xDEADBEEF one cycle after acceptance.
REQ-033 Write addr 3 = 0x1 then write addr 3 = 0x2 back-to-back -> second rsp hit=1 data=0x1, count stays 1.
REQ-034 Delete addr 5 (invalid), then delete addr 3 (holding 0x2) -> rsp hit=0/data=0, count 1; then hit=1/data=0x2, count 0.
REQ-035 Fill entries 0..15, issue clear-all with req_valid held high -> busy=1 and req_ready=0 for 16 cycles, count decrements 16->0, single rsp_valid at end, later requests accepted only after IDLE.
REQ-036 Assert reset 5 cycles into a clear-all -> no rsp_valid, count=0, busy=0, req_ready=1 the cycle after reset deasserts.
REQ-037 DEPTH=12 build, write addr 13 = 0xAA -> rsp hit=0 data=0, count unchanged, all entries unchanged.

Source files
------------

// File: rtl/cash_data_bank.sv
// cash_data_bank: small keyed data store with per-entry valid bits.
//
// Each entry holds a DATA_WIDTH data word and a valid bit. Read, write and
// delete complete in one cycle and return the entry's prior contents one
// cycle after acceptance. Clear-all sweeps the entries one per cycle and
// returns a single response once the last entry has been cleared.
//
// Ports
//   clk        : clock, all state updates on its rising edge
//   reset      : synchronous, active-high reset
//   req_valid  : request present
//   req_ready  : bank can accept a request (idle and not in reset)
//   req_op     : 00 read, 01 write, 10 delete, 11 clear-all
//   req_addr   : entry index (ignored for clear-all)
//   req_data   : write data (ignored for other ops)
//   rsp_valid  : one-cycle response strobe
//   rsp_data   : entry data before the operation (0 if invalid)
//   rsp_hit    : entry was valid before the operation
//   count      : number of valid entries
//   busy       : clear-all sweep in progress
module cash_data_bank #(
    parameter int unsigned  DATA_WIDTH = 32,
    parameter int unsigned  DEPTH      = 16,
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_hit,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  busy
);

    typedef enum logic [1:0] {
        OpRead   = 2'b00,
        OpWrite  = 2'b01,
        OpDelete = 2'b10,
        OpClear  = 2'b11
    } op_e;

    typedef enum logic {
        StIdle  = 1'b0,
        StClear = 1'b1
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(DEPTH - 1);

    // Declaration initialisers give power-up values equal to reset values.
    state_e                state_q = StIdle;
    state_e                state_d;
    logic [ADDR_WIDTH-1:0] idx_q = '0;
    logic [ADDR_WIDTH-1:0] idx_d;
    logic [ADDR_WIDTH:0]   count_q = '0;
    logic [ADDR_WIDTH:0]   count_d;
    logic [DATA_WIDTH-1:0] data_q [DEPTH] = '{default: '0};
    logic [DATA_WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0]      valid_q = '0;
    logic [DEPTH-1:0]      valid_d;
    logic                  rsp_valid_q = 1'b0;
    logic                  rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q = '0;
    logic [DATA_WIDTH-1:0] rsp_data_d;
    logic                  rsp_hit_q = 1'b0;
    logic                  rsp_hit_d;

    logic                  accept;
    logic                  addr_ok;
    logic                  prior_valid;
    logic [DATA_WIDTH-1:0] prior_data;

    assign req_ready = (state_q == StIdle) && !reset;
    assign accept    = req_valid && req_ready;

    // Widen before comparing so non-power-of-two depths are range-checked.
    assign addr_ok     = 32'(req_addr) < DEPTH;
    assign prior_valid = addr_ok && valid_q[req_addr];
    assign prior_data  = prior_valid ? data_q[req_addr] : '0;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        count_d     = count_q;
        data_d      = data_q;
        valid_d     = valid_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = '0;
        rsp_hit_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (op_e'(req_op) == OpClear) begin
                        state_d = StClear;
                        idx_d   = '0;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_hit_d   = prior_valid;
                        rsp_data_d  = prior_data;
                        if (addr_ok) begin
                            unique case (op_e'(req_op))
                                OpWrite: begin
                                    data_d[req_addr]  = req_data;
                                    valid_d[req_addr] = 1'b1;
                                    if (!prior_valid) count_d = count_q + 1'b1;
                                end
                                OpDelete: begin
                                    data_d[req_addr]  = '0;
                                    valid_d[req_addr] = 1'b0;
                                    if (prior_valid) count_d = count_q - 1'b1;
                                end
                                default: ;  // read: no state change
                            endcase
                        end
                    end
                end
            end
            StClear: begin
                data_d[idx_q]  = '0;
                valid_d[idx_q] = 1'b0;
                if (valid_q[idx_q]) count_d = count_q - 1'b1;
                if (idx_q == LastIdx) begin
                    // Response lands in the first idle cycle, with count at 0.
                    state_d     = StIdle;
                    idx_d       = '0;
                    rsp_valid_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            count_q     <= '0;
            data_q      <= '{default: '0};
            valid_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_hit_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            count_q     <= count_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_hit_q   <= rsp_hit_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_hit   = rsp_hit_q;
    assign count     = count_q;
    assign busy      = (state_q == StClear);

endmodule

// File: tb/tb_cash_data_bank.sv
module tb_cash_data_bank;
    localparam int unsigned DW      = 32;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned AW      = 4;
    localparam int unsigned DEPTH_B = 12;
    localparam int unsigned AW_B    = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = '0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_data = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_hit;
    logic [AW:0]   count;
    logic          busy;

    logic            b_req_valid = 1'b0;
    logic            b_req_ready;
    logic [1:0]      b_req_op = '0;
    logic [AW_B-1:0] b_req_addr = '0;
    logic [DW-1:0]   b_req_data = '0;
    logic            b_rsp_valid;
    logic [DW-1:0]   b_rsp_data;
    logic            b_rsp_hit;
    logic [AW_B:0]   b_count;
    logic            b_busy;

    cash_data_bank #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_hit   (rsp_hit),
        .count     (count),
        .busy      (busy)
    );

    cash_data_bank #(.DATA_WIDTH(DW), .DEPTH(DEPTH_B)) u_dut_b (
        .clk       (clk),
        .reset     (reset),
        .req_valid (b_req_valid),
        .req_ready (b_req_ready),
        .req_op    (b_req_op),
        .req_addr  (b_req_addr),
        .req_data  (b_req_data),
        .rsp_valid (b_rsp_valid),
        .rsp_data  (b_rsp_data),
        .rsp_hit   (b_rsp_hit),
        .count     (b_count),
        .busy      (b_busy)
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model: plain arrays; count is the population of valid entries.
    logic [DW-1:0] m_data  [DEPTH];
    bit            m_vld   [DEPTH];
    logic [DW-1:0] mb_data [DEPTH_B];
    bit            mb_vld  [DEPTH_B];

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += int'(m_vld[i]);
        return n;
    endfunction

    function automatic int mb_count();
        int n = 0;
        for (int i = 0; i < DEPTH_B; i++) n += int'(mb_vld[i]);
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_data[i] = '0;
            m_vld[i]  = 1'b0;
        end
        for (int i = 0; i < DEPTH_B; i++) begin
            mb_data[i] = '0;
            mb_vld[i]  = 1'b0;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Idle cycle on bank A: no response may appear, outputs must be zero.
    task automatic idle_a(input string tag);
        req_valid = 1'b0;
        step();
        check({tag, " rsp_valid"}, 64'(rsp_valid), 64'(0));
        check({tag, " rsp_hit"}, 64'(rsp_hit), 64'(0));
        check({tag, " rsp_data"}, 64'(rsp_data), 64'(0));
    endtask

    task automatic issue(input logic [1:0] op, input int addr, input logic [DW-1:0] data);
        logic          e_hit;
        logic [DW-1:0] e_data;
        string         t;
        t = $sformatf("A op%0d a%0d", op, addr);
        check({t, " req_ready"}, 64'(req_ready), 64'(1));
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = AW'(addr);
        req_data  = data;
        e_hit  = m_vld[addr];
        e_data = m_vld[addr] ? m_data[addr] : '0;
        if (op == 2'd1) begin
            m_data[addr] = data;
            m_vld[addr]  = 1'b1;
        end else if (op == 2'd2) begin
            m_data[addr] = '0;
            m_vld[addr]  = 1'b0;
        end
        step();
        req_valid = 1'b0;
        check({t, " rsp_valid"}, 64'(rsp_valid), 64'(1));
        check({t, " rsp_hit"}, 64'(rsp_hit), 64'(e_hit));
        check({t, " rsp_data"}, 64'(rsp_data), 64'(e_data));
        check({t, " count"}, 64'(count), 64'(m_count()));
    endtask

    task automatic b_issue(input logic [1:0] op, input int addr, input logic [DW-1:0] data);
        logic          e_hit;
        logic [DW-1:0] e_data;
        string         t;
        bit            in_range;
        t = $sformatf("B op%0d a%0d", op, addr);
        in_range = (addr < DEPTH_B);
        check({t, " req_ready"}, 64'(b_req_ready), 64'(1));
        b_req_valid = 1'b1;
        b_req_op    = op;
        b_req_addr  = AW_B'(addr);
        b_req_data  = data;
        e_hit  = in_range ? mb_vld[addr] : 1'b0;
        e_data = (in_range && mb_vld[addr]) ? mb_data[addr] : '0;
        if (in_range && op == 2'd1) begin
            mb_data[addr] = data;
            mb_vld[addr]  = 1'b1;
        end else if (in_range && op == 2'd2) begin
            mb_data[addr] = '0;
            mb_vld[addr]  = 1'b0;
        end
        step();
        b_req_valid = 1'b0;
        check({t, " rsp_valid"}, 64'(b_rsp_valid), 64'(1));
        check({t, " rsp_hit"}, 64'(b_rsp_hit), 64'(e_hit));
        check({t, " rsp_data"}, 64'(b_rsp_data), 64'(e_data));
        check({t, " count"}, 64'(b_count), 64'(mb_count()));
    endtask

    // Clear-all with req_valid held high throughout the sweep.
    task automatic issue_clear();
        check("clr req_ready", 64'(req_ready), 64'(1));
        req_valid = 1'b1;
        req_op    = 2'd3;
        step();
        req_op = 2'd0;
        for (int j = 0; j < int'(DEPTH); j++) begin
            string t;
            t = $sformatf("clr sweep%0d", j);
            check({t, " busy"}, 64'(busy), 64'(1));
            check({t, " req_ready"}, 64'(req_ready), 64'(0));
            check({t, " rsp_valid"}, 64'(rsp_valid), 64'(0));
            check({t, " count"}, 64'(count), 64'(m_count()));
            m_data[j] = '0;
            m_vld[j]  = 1'b0;
            req_addr  = AW'(j);
            step();
        end
        check("clr done rsp_valid", 64'(rsp_valid), 64'(1));
        check("clr done rsp_hit", 64'(rsp_hit), 64'(0));
        check("clr done rsp_data", 64'(rsp_data), 64'(0));
        check("clr done count", 64'(count), 64'(0));
        check("clr done busy", 64'(busy), 64'(0));
        check("clr done req_ready", 64'(req_ready), 64'(1));
        // The read still held on the bus is accepted now that the bank is idle.
        step();
        req_valid = 1'b0;
        check("post-clr read rsp_valid", 64'(rsp_valid), 64'(1));
        check("post-clr read rsp_hit", 64'(rsp_hit), 64'(0));
        check("post-clr read rsp_data", 64'(rsp_data), 64'(0));
    endtask

    initial begin
        model_reset();

        // Reset state.
        reset = 1'b1;
        step();
        step();
        check("rst rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst rsp_hit", 64'(rsp_hit), 64'(0));
        check("rst rsp_data", 64'(rsp_data), 64'(0));
        check("rst count", 64'(count), 64'(0));
        check("rst busy", 64'(busy), 64'(0));
        check("rst req_ready in reset", 64'(req_ready), 64'(0));
        reset = 1'b0;
        #1;
        check("rst req_ready after", 64'(req_ready), 64'(1));

        // Write then read back.
        issue(2'd1, 3, 32'hDEADBEEF);
        issue(2'd0, 3, '0);
        // Back-to-back overwrites.
        issue(2'd1, 3, 32'h1);
        issue(2'd1, 3, 32'h2);
        // Delete invalid, then valid entry.
        issue(2'd2, 5, '0);
        issue(2'd2, 3, '0);
        idle_a("idle0");

        // Random read/write/delete traffic with occasional idle cycles.
        for (int i = 0; i < 400; i++) begin
            int r;
            if ($urandom_range(0, 3) == 0) begin
                idle_a("rnd idle");
            end else begin
                r = int'($urandom_range(0, 9));
                if (r < 4)      issue(2'd1, int'($urandom_range(0, DEPTH - 1)), DW'($urandom));
                else if (r < 7) issue(2'd0, int'($urandom_range(0, DEPTH - 1)), DW'($urandom));
                else            issue(2'd2, int'($urandom_range(0, DEPTH - 1)), DW'($urandom));
            end
        end

        // Fill every entry, then clear-all.
        for (int i = 0; i < int'(DEPTH); i++) issue(2'd1, i, DW'($urandom) | 32'h1);
        issue_clear();
        idle_a("idle1");

        // Reset in the middle of a clear-all sweep.
        for (int i = 0; i < 8; i++) issue(2'd1, i, DW'($urandom) | 32'h1);
        req_valid = 1'b1;
        req_op    = 2'd3;
        step();
        req_valid = 1'b0;
        req_op    = 2'd0;
        for (int i = 0; i < 4; i++) step();
        check("abort busy before", 64'(busy), 64'(1));
        reset = 1'b1;
        step();
        check("abort rsp_valid", 64'(rsp_valid), 64'(0));
        check("abort count", 64'(count), 64'(0));
        check("abort busy", 64'(busy), 64'(0));
        reset = 1'b0;
        model_reset();
        #1;
        check("abort req_ready", 64'(req_ready), 64'(1));
        idle_a("abort idle");
        issue(2'd0, 7, '0);

        // Out-of-range index on a non-power-of-two bank.
        b_issue(2'd1, 2, 32'h55);
        b_issue(2'd1, 13, 32'hAA);
        b_issue(2'd0, 13, '0);
        b_issue(2'd2, 13, '0);
        for (int i = 0; i < int'(DEPTH_B); i++) b_issue(2'd0, i, '0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
